// File: rtl/wave_pkg.sv
// wave_pkg: shared types for the wave lattice datapath and the stencil feeder.
package wave_pkg;
    localparam int PSI_WIDTH   = 16;
    localparam int V_WIDTH     = 16;
    localparam int COORD_WIDTH = 8;

    typedef struct packed {
        logic signed [PSI_WIDTH-1:0] re;
        logic signed [PSI_WIDTH-1:0] im;
    } complex_t;

    localparam complex_t PSI_ZERO = '0;

    typedef enum logic [1:0] {FS_IDLE, FS_FILL, FS_STREAM, FS_FLUSH} feeder_state_e;

    typedef struct packed {
        complex_t                  n, s, e, w, c;
        logic signed [V_WIDTH-1:0] pot;
        logic [COORD_WIDTH-1:0]    x, y;
        logic                      last;
    } stencil_t;
endpackage

// File: rtl/wave_stencil_feeder_line_buffer.sv
// wave_line_buffer: one lattice row of registers, one write port and two combinational read ports.
module wave_line_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];
endmodule

// File: rtl/wave_stencil_feeder.sv
// wave_stencil_feeder: turns a raster Psi/V frame into 5-point stencil windows
// with zero Dirichlet boundary, using a north row and a centre row buffer.
module wave_stencil_feeder
    import wave_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      frame_done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  complex_t                  in_psi,
    input  logic signed [V_WIDTH-1:0] in_pot,
    output logic                      out_valid,
    input  logic                      out_ready,
    output complex_t                  out_psi_n,
    output complex_t                  out_psi_s,
    output complex_t                  out_psi_e,
    output complex_t                  out_psi_w,
    output complex_t                  out_psi_c,
    output logic signed [V_WIDTH-1:0] out_pot,
    output logic [XW-1:0]             out_x,
    output logic [YW-1:0]             out_y,
    output logic                      out_last
);
    localparam logic [1:0] IDLE   = FS_IDLE;
    localparam logic [1:0] FILL   = FS_FILL;
    localparam logic [1:0] STREAM = FS_STREAM;
    localparam logic [1:0] FLUSH  = FS_FLUSH;
    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);
    localparam int CW = $bits(complex_t) + V_WIDTH;

    logic [1:0]    state;
    logic [XW-1:0] col, w_addr, e_addr, col_next;
    logic [YW-1:0] row, site_y;
    logic          slot_free, fill_acc, stream_acc, load;
    complex_t      n_raw, w_raw;
    logic [CW-1:0] c_word, e_word;
    stencil_t      win, win_d;

    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = state == FILL || (state == STREAM && slot_free);
    assign fill_acc   = state == FILL && in_valid;
    assign stream_acc = state == STREAM && in_valid && slot_free;
    assign load       = stream_acc || (state == FLUSH && slot_free);
    assign col_next   = col == X_LAST ? '0 : col + XW'(1);
    assign w_addr     = col - XW'(1);
    assign e_addr     = col_next;
    assign site_y     = state == FLUSH ? row : row - YW'(1);

    // Each window load shifts buf_c[col] into buf_n[col]; so W (col-1) is
    // already the pre-overwrite centre value, found in the north buffer.
    wave_line_buffer #(.DEPTH(GRID_W), .WIDTH($bits(complex_t))) u_buf_n (
        .clk       (clk),
        .wr_en     (load),
        .wr_addr   (col),
        .wr_data   (c_word[CW-1:V_WIDTH]),
        .rd_addr_a (col),
        .rd_data_a (n_raw),
        .rd_addr_b (w_addr),
        .rd_data_b (w_raw)
    );

    wave_line_buffer #(.DEPTH(GRID_W), .WIDTH(CW)) u_buf_c (
        .clk       (clk),
        .wr_en     (fill_acc || stream_acc),
        .wr_addr   (col),
        .wr_data   ({in_psi, in_pot}),
        .rd_addr_a (col),
        .rd_data_a (c_word),
        .rd_addr_b (e_addr),
        .rd_data_b (e_word)
    );

    always_comb begin
        win_d      = '0;
        win_d.n    = state == STREAM && row == YW'(1) ? PSI_ZERO : n_raw;
        win_d.s    = state == STREAM ? in_psi : PSI_ZERO;
        win_d.e    = col == X_LAST ? PSI_ZERO : complex_t'(e_word[CW-1:V_WIDTH]);
        win_d.w    = col == '0 ? PSI_ZERO : w_raw;
        win_d.c    = c_word[CW-1:V_WIDTH];
        win_d.pot  = c_word[V_WIDTH-1:0];
        win_d.x    = COORD_WIDTH'(col);
        win_d.y    = COORD_WIDTH'(site_y);
        win_d.last = state == FLUSH && col == X_LAST;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            win       <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                win       <= win_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    state <= FILL;
                    col   <= '0;
                    row   <= '0;
                end
                FILL: if (fill_acc) begin
                    col <= col_next;
                    if (col == X_LAST) begin
                        row   <= YW'(1);
                        state <= STREAM;
                    end
                end
                STREAM: if (stream_acc) begin
                    col <= col_next;
                    if (col == X_LAST) begin
                        if (row == Y_LAST) state <= FLUSH;
                        else row <= row + YW'(1);
                    end
                end
                FLUSH: if (slot_free) begin
                    col <= col_next;
                    if (col == X_LAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = state != IDLE || out_valid;
    assign frame_done = out_valid && out_ready &&
                        win.x == COORD_WIDTH'(GRID_W - 1) && win.y == COORD_WIDTH'(GRID_H - 1);
    assign out_psi_n  = win.n;
    assign out_psi_s  = win.s;
    assign out_psi_e  = win.e;
    assign out_psi_w  = win.w;
    assign out_psi_c  = win.c;
    assign out_pot    = win.pot;
    assign out_x      = win.x[XW-1:0];
    assign out_y      = win.y[YW-1:0];
    assign out_last   = win.last;
endmodule

// File: tb/tb_wave_stencil_feeder.sv
// tb_wave_stencil_feeder: scoreboard bench; expected windows come from a 2-D frame model.
module tb_wave_stencil_feeder;
    import wave_pkg::*;

    localparam int GW = 4;
    localparam int GH = 3;

    typedef struct packed {
        complex_t                  n, s, e, w, c;
        logic signed [V_WIDTH-1:0] pot;
        logic [1:0]                x, y;
        logic                      last;
    } win_t;

    logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 1;
    complex_t in_psi = '0;
    logic signed [V_WIDTH-1:0] in_pot = '0;
    logic busy, frame_done, in_ready, out_valid, out_last;
    complex_t out_psi_n, out_psi_s, out_psi_e, out_psi_w, out_psi_c;
    logic signed [V_WIDTH-1:0] out_pot;
    logic [1:0] out_x, out_y;

    always #5 clk = ~clk;

    wave_stencil_feeder #(.GRID_W(GW), .GRID_H(GH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_psi(in_psi), .in_pot(in_pot),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_psi_n(out_psi_n), .out_psi_s(out_psi_s), .out_psi_e(out_psi_e),
        .out_psi_w(out_psi_w), .out_psi_c(out_psi_c), .out_pot(out_pot),
        .out_x(out_x), .out_y(out_y), .out_last(out_last)
    );

    win_t exp_q[$];
    complex_t fpsi[GH][GW];
    logic signed [V_WIDTH-1:0] fpot[GH][GW];
    int total = 0, bad = 0, done_cnt = 0, win_cnt = 0, rmode = 0;
    bit armed = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic complex_t tap(input int x, input int y);
        if (x < 0 || x >= GW || y < 0 || y >= GH) return PSI_ZERO;
        return fpsi[y][x];
    endfunction

    // kinds: 0 ramp, 1 ramp+random im/V, 2 ramp with im=-x, 3 full scale, 4 random
    task automatic build(input int kind);
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) begin
                fpsi[y][x].re = PSI_WIDTH'(16 * y + x);
                fpsi[y][x].im = '0;
                fpot[y][x]    = V_WIDTH'(x);
                if (kind == 1) begin
                    fpsi[y][x].im = PSI_WIDTH'($urandom);
                    fpot[y][x]    = V_WIDTH'($urandom);
                end
                if (kind == 2) fpsi[y][x].im = PSI_WIDTH'(-x);
                if (kind == 3) begin
                    fpsi[y][x] = {16'h7FFF, 16'h8000};
                    fpot[y][x] = 16'h8000;
                end
                if (kind == 4) begin
                    fpsi[y][x] = $urandom;
                    fpot[y][x] = V_WIDTH'($urandom);
                end
            end
    endtask

    task automatic push_expected();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                exp_q.push_back('{n: tap(x, y - 1), s: tap(x, y + 1), e: tap(x + 1, y),
                                  w: tap(x - 1, y), c: tap(x, y), pot: fpot[y][x],
                                  x: 2'(x), y: 2'(y), last: (x == GW - 1 && y == GH - 1)});
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input complex_t p, input logic signed [V_WIDTH-1:0] v);
        int t = 0;
        in_valid = 1; in_psi = p; in_pot = v;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL in_ready_timeout got=0 want=1");
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic run(input int kind, input int mode, input int gap, input bit mid);
        int d0, w0, t;
        build(kind);
        rmode = mode; d0 = done_cnt; w0 = win_cnt; t = 0;
        push_expected();
        pulse_start();
        for (int i = 0; i < GW * GH; i++) begin
            send(fpsi[i / GW][i % GW], fpot[i / GW][i % GW]);
            repeat (gap) begin @(posedge clk); #1; end
            if (mid && i == 5) pulse_start();
        end
        while ((exp_q.size() != 0 || out_valid) && t < 1000) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("window_count", win_cnt - w0, GW * GH);
        chk("frame_done_count", done_cnt - d0, 1);
        chk("busy_after_frame", busy, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin : ready_drv
        int phase = 0;
        forever begin
            @(posedge clk); #1;
            out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (phase == 0 || phase == 3) : 1'($urandom_range(0, 1));
            phase = (phase + 1) % 4;
        end
    end

    always @(negedge clk) begin : monitor
        win_t g, e;
        if (rst_n) begin
            if (frame_done) done_cnt++;
            if (out_valid && !out_ready) chk("in_ready_while_held", in_ready, 0);
            if (busy) armed = 1;
            if (armed && exp_q.size() != 0) chk("busy_during_frame", busy, 1);
            if (exp_q.size() == 0) armed = 0;
            if (out_valid && out_ready) begin
                g = '{n: out_psi_n, s: out_psi_s, e: out_psi_e, w: out_psi_w, c: out_psi_c,
                      pot: out_pot, x: out_x, y: out_y, last: out_last};
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL extra_window got x=%0d y=%0d want none", out_x, out_y);
                end else begin
                    e = exp_q.pop_front();
                    win_cnt++;
                    chk($sformatf("window(%0d,%0d)", e.x, e.y), g, e);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_data", {out_psi_c, out_psi_n, out_pot, out_x, out_y, out_last}, 0);
        rst_n = 1;
        @(posedge clk); #1;
        run(0, 0, 0, 0);
        run(0, 1, 0, 0);
        run(0, 0, 3, 0);
        run(1, 2, 0, 1);
        // abort a frame after 6 samples, then check a clean restart
        build(0);
        push_expected();
        rmode = 0;
        pulse_start();
        for (int i = 0; i < 6; i++) send(fpsi[i / GW][i % GW], fpot[i / GW][i % GW]);
        rst_n = 0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run(2, 0, 0, 0);
        run(3, 1, 0, 0);
        run(4, 2, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
